// File: rtl/prbs_burst_sequencer.sv
// PRBS burst sequencer: takes burst commands, pulses an external LFSR's reseed,
// and streams its output bits with a valid/ready handshake.
module prbs_burst_sequencer #(
    parameter int LW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [LW-1:0] i_cmd_len,
    input  logic          i_cmd_restart,
    input  logic          i_abort,
    output logic          o_lfsr_reset,
    output logic          o_lfsr_ce,
    output logic          o_lfsr_in,
    input  logic          i_lfsr_bit,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [LW-1:0] o_remaining
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESEED = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [LW-1:0] count_r;
    logic [LW-1:0] count_s;
    logic          hs_s;

    assign hs_s = (state_r == ST_STREAM) && i_ready;

    // State and remaining-bit counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            count_r <= {LW{1'b0}};
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    count_s = i_cmd_len;
                    if (i_cmd_len == {LW{1'b0}}) begin
                        state_s = ST_DONE;
                    end else if (i_cmd_restart) begin
                        state_s = ST_RESEED;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RESEED: begin
                // the reseed pulse always completes; abort only skips streaming
                if (i_abort) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (hs_s) begin
                    count_s = count_r - {{(LW-1){1'b0}}, 1'b1};
                end else begin
                    count_s = count_r;
                end
                if (i_abort || (hs_s && (count_r == {{(LW-1){1'b0}}, 1'b1}))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = {LW{1'b0}};
            end
        endcase
    end

    // Output decode; LFSR reset also follows the async reset so it refills meanwhile
    always_comb begin
        o_cmd_ready  = 1'b0;
        o_valid      = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_lfsr_in    = 1'b0;
        o_remaining  = count_r;
        o_lfsr_reset = ~i_reset_n;
        case (state_r)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
            end
            ST_RESEED: begin
                o_lfsr_reset = 1'b1;
            end
            ST_STREAM: begin
                o_valid = 1'b1;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
        o_data    = o_valid & i_lfsr_bit;
        o_lfsr_ce = o_valid & i_ready;
    end

endmodule

// File: tb/tb_prbs_burst_sequencer.sv
// Bench for prbs_burst_sequencer: drives an 8-bit LFSR environment and checks
// every cycle of directed and random bursts against a bit-index reference.
module tb_prbs_burst_sequencer;

    localparam int LW = 16;
    localparam int SEQ_N = 8192;

    logic          i_clk;
    logic          i_reset_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [LW-1:0] i_cmd_len;
    logic          i_cmd_restart;
    logic          i_abort;
    logic          o_lfsr_reset;
    logic          o_lfsr_ce;
    logic          o_lfsr_in;
    logic          i_lfsr_bit;
    logic          o_valid;
    logic          i_ready;
    logic          o_data;
    logic          o_busy;
    logic          o_done;
    logic [LW-1:0] o_remaining;

    logic [7:0]    lfsr_q;
    bit            seq [SEQ_N];
    int            pos;
    int            n_vec;
    int            n_err;

    prbs_burst_sequencer #(.LW(LW)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_len    (i_cmd_len),
        .i_cmd_restart(i_cmd_restart),
        .i_abort      (i_abort),
        .o_lfsr_reset (o_lfsr_reset),
        .o_lfsr_ce    (o_lfsr_ce),
        .o_lfsr_in    (o_lfsr_in),
        .i_lfsr_bit   (i_lfsr_bit),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_remaining  (o_remaining)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // External LFSR: LN=8, TAPS=0x2d, fill=0x01, shift right, output bit 0
    always @(posedge i_clk) begin
        if (o_lfsr_reset) lfsr_q <= 8'h01;
        else if (o_lfsr_ce) lfsr_q <= {(^(lfsr_q & 8'h2d)) ^ o_lfsr_in, lfsr_q[7:1]};
    end
    assign i_lfsr_bit = lfsr_q[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(negedge i_clk);
    endtask

    // One complete burst; reset_after > 0 asserts async reset after that many bits.
    task automatic run_burst(input int len, input bit restart, input int abort_cyc,
                             input bit reseed_abort, input int rmode, input int reset_after);
        int  rem;
        int  cyc;
        bit  rdy;
        bit  ab;
        bit  fin;
        next_cyc();
        i_cmd_valid = 1'b1; i_cmd_len = LW'(len); i_cmd_restart = restart;
        i_ready = 1'b1; i_abort = 1'b0;
        #1;
        chk("idle_cmd_ready", o_cmd_ready, 1);
        chk("idle_busy", o_busy, 0);
        chk("idle_ce", o_lfsr_ce, 0);
        chk("idle_lfsr_reset", o_lfsr_reset, 0);
        next_cyc();
        i_cmd_valid = 1'b0; i_cmd_len = LW'($urandom);
        rem = len;
        if (len != 0) begin
            if (restart) begin
                i_abort = reseed_abort;
                i_ready = 1'b1;
                #1;
                chk("reseed_pulse", o_lfsr_reset, 1);
                chk("reseed_valid", o_valid, 0);
                chk("reseed_ce", o_lfsr_ce, 0);
                chk("reseed_rem", o_remaining, 32'(len));
                pos = 0;
                next_cyc();
                i_abort = 1'b0;
            end
            if (!(restart && reseed_abort)) begin
                cyc = 0; fin = 1'b0;
                while (!fin) begin
                    if (reset_after > 0 && (len - rem) == reset_after) begin
                        i_reset_n = 1'b0;
                        #1;
                        chk("rst_valid", o_valid, 0);
                        chk("rst_busy", o_busy, 0);
                        chk("rst_ce", o_lfsr_ce, 0);
                        chk("rst_lfsr_reset", o_lfsr_reset, 1);
                        next_cyc();
                        #1;
                        chk("rst_hold_lfsr_reset", o_lfsr_reset, 1);
                        chk("rst_no_done", o_done, 0);
                        i_reset_n = 1'b1;
                        pos = 0;
                        #1;
                        chk("rst_release_busy", o_busy, 0);
                        chk("rst_release_lfsr_reset", o_lfsr_reset, 0);
                        i_ready = 1'b0;
                        return;
                    end
                    case (rmode)
                        0:       rdy = 1'b1;
                        1:       rdy = (cyc % 2) == 0;
                        default: rdy = ($urandom_range(3, 0) != 0);
                    endcase
                    ab = (cyc + 1 == abort_cyc);
                    i_ready = rdy; i_abort = ab;
                    #1;
                    chk("st_valid", o_valid, 1);
                    chk("st_data", o_data, 32'(seq[pos]));
                    chk("st_ce", o_lfsr_ce, 32'(rdy));
                    chk("st_lfsr_reset", o_lfsr_reset, 0);
                    chk("st_rem", o_remaining, 32'(rem));
                    if (rdy) begin pos++; rem--; end
                    cyc++;
                    if (rem == 0 || ab) fin = 1'b1;
                    else if (cyc > 4 * len + 40) begin
                        chk("stream_timeout", 0, 1);
                        fin = 1'b1;
                    end
                    next_cyc();
                end
            end
        end
        i_ready = 1'b1; i_abort = 1'($urandom);
        #1;
        chk("done_pulse", o_done, 1);
        chk("done_cmd_ready", o_cmd_ready, 0);
        chk("done_valid", o_valid, 0);
        chk("done_ce", o_lfsr_ce, 0);
        chk("done_lfsr_reset", o_lfsr_reset, 0);
        chk("done_rem", o_remaining, 32'(rem));
        next_cyc();
        i_abort = 1'b0; i_ready = 1'b0;
        #1;
        chk("post_done", o_done, 0);
        chk("post_busy", o_busy, 0);
        chk("post_cmd_ready", o_cmd_ready, 1);
        chk("post_rem_hold", o_remaining, 32'(rem));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_err = 0; pos = 0;
        // Reference bit stream: b[k+8] = b[k]^b[k+2]^b[k+3]^b[k+5], b[0..7] = fill bits
        for (int k = 0; k < 8; k++) seq[k] = (k == 0);
        for (int k = 8; k < SEQ_N; k++) seq[k] = seq[k-8] ^ seq[k-6] ^ seq[k-5] ^ seq[k-3];

        i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_len = '0; i_cmd_restart = 1'b0;
        i_abort = 1'b0; i_ready = 1'b0;
        repeat (3) next_cyc();
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_ce", o_lfsr_ce, 0);
        chk("reset_lfsr_reset", o_lfsr_reset, 1);
        chk("reset_rem", o_remaining, 0);
        chk("lfsr_in_zero", o_lfsr_in, 0);
        i_reset_n = 1'b1;

        run_burst(9, 1'b1, 0, 1'b0, 0, 0);
        run_burst(9, 1'b1, 0, 1'b0, 1, 0);
        run_burst(4, 1'b1, 0, 1'b0, 0, 0);
        run_burst(5, 1'b0, 0, 1'b0, 0, 0);
        run_burst(0, 1'b1, 0, 1'b0, 0, 0);
        run_burst(9, 1'b1, 3, 1'b0, 0, 0);
        run_burst(2, 1'b0, 0, 1'b0, 0, 0);
        run_burst(9, 1'b1, 0, 1'b0, 0, 2);
        run_burst(3, 1'b0, 0, 1'b0, 0, 0);
        run_burst(5, 1'b1, 0, 1'b1, 0, 0);
        run_burst(6, 1'b0, 0, 1'b0, 2, 0);

        for (int b = 0; b < 150; b++) begin
            int len;
            len = $urandom_range(24, 0);
            run_burst(len, 1'($urandom), ($urandom_range(3, 0) == 0) ? $urandom_range(len + 1, 1) : 0,
                      ($urandom_range(7, 0) == 0), $urandom_range(2, 0), 0);
            if (pos > SEQ_N - 64) pos = SEQ_N - 64;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
